filter_stream_sp: RTL and testbench

//  Multi-filter scratchpad for the conv PE datapath: holds NUM_FILTERS kernels of up to FILTER_ROW words.

---
 rtl/filter_sp_pkg.sv | 19 +
 rtl/filter_sp_bank.sv | 28 ++
 rtl/filter_stream_sp.sv | 189 ++++++++++++++++++
 tb/tb_filter_stream_sp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sp_pkg.sv
// Shared types and width helpers for the filter scratchpad.
package filter_sp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Index width that never collapses to zero for tiny sizes.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int eff_len_f(input int len, input int rows);
      return (len == 0 || len > rows) ? rows : len;
   endfunction

endpackage

// File: rtl/filter_sp_bank.sv
// One filter bank: 1W/1R word array, cleared on reset, combinational read.
module filter_sp_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 12,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= din_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/filter_stream_sp.sv
// Multi-filter scratchpad with auto-addressed valid/ready read stream.
// Optional multi-pass streaming is enabled by defining FILTER_SP_REPEAT_EN.
//
// state  | meaning
// IDLE   | waiting for start; writes to any filter allowed
// STREAM | dout_valid high, words advancing on each handshake
// DONE   | one-cycle done pulse, then back to IDLE
module filter_stream_sp
   import filter_sp_pkg::*;
#(
   parameter  int FILTER_WIDTH = 16,
   parameter  int FILTER_ROW   = 12,
   parameter  int NUM_FILTERS  = 4,
   parameter  int REP_W        = 4,
   localparam int ADDR_W       = clog2_min1(FILTER_ROW),
   localparam int SEL_W        = clog2_min1(NUM_FILTERS),
   localparam int LEN_W        = ADDR_W + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wen,
   input  logic [SEL_W-1:0]        wsel,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [FILTER_WIDTH-1:0] din,
   output logic                    wr_err,
   input  logic                    start,
   input  logic [SEL_W-1:0]        rsel,
   input  logic [LEN_W-1:0]        len,
   input  logic [REP_W-1:0]        repeat_n,
   input  logic                    flush,
   output logic [FILTER_WIDTH-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    busy,
   output logic                    done
);

   state_e                  state_q, state_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [ADDR_W-1:0]       ptr_q, ptr_d;
   logic [FILTER_WIDTH-1:0] dout_q, dout_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    wr_err_q;

   logic [LEN_W-1:0]        eff_len;
   logic [SEL_W-1:0]        start_sel;
   logic                    wr_bad, wr_ok, ptr_wrap, final_pass;
   logic [SEL_W-1:0]        rd_sel;
   logic [ADDR_W-1:0]       rd_addr;
   logic [FILTER_WIDTH-1:0] rd_data;
   logic [FILTER_WIDTH-1:0] bank_rdata [NUM_FILTERS];

   assign eff_len   = LEN_W'(eff_len_f(int'(len), FILTER_ROW));
   assign start_sel = (int'(rsel) >= NUM_FILTERS) ? '0 : rsel;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

   // The filter being streamed is write-locked for the whole stream.
   assign wr_bad = (int'(waddr) >= FILTER_ROW) || (int'(wsel) >= NUM_FILTERS) ||
                   (busy && (wsel == sel_q));
   assign wr_ok  = wen && !wr_bad;

   assign rd_sel  = (state_q == IDLE) ? start_sel : sel_q;
   assign rd_addr = (state_q == IDLE) ? '0 : ptr_q;
   assign rd_data = bank_rdata[rd_sel];

   for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_bank
      filter_sp_bank #(
         .WIDTH (FILTER_WIDTH),
         .DEPTH (FILTER_ROW),
         .AW    (ADDR_W)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (wr_ok && (wsel == SEL_W'(g))),
         .waddr_i (waddr),
         .din_i   (din),
         .raddr_i (rd_addr),
         .rdata_o (bank_rdata[g])
      );
   end

   assign ptr_wrap = ({1'b0, ptr_q} == (len_q - LEN_W'(1)));

`ifdef FILTER_SP_REPEAT_EN
   // pass_q is the pass that the word at ptr_q belongs to.
   logic [REP_W-1:0] pass_q, pass_d, rep_q, rep_d;
   assign final_pass = (pass_q == rep_q);
`else
   logic unused_repeat_n;
   assign unused_repeat_n = ^repeat_n;
   assign final_pass      = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      last_d  = last_q;
`ifdef FILTER_SP_REPEAT_EN
      pass_d  = pass_q;
      rep_d   = rep_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = start_sel;
               len_d   = eff_len;
               dout_d  = rd_data;
               valid_d = 1'b1;
               ptr_d   = (eff_len == LEN_W'(1)) ? '0 : ADDR_W'(1);
               state_d = STREAM;
`ifdef FILTER_SP_REPEAT_EN
               rep_d   = repeat_n;
               pass_d  = (eff_len == LEN_W'(1)) ? REP_W'(1) : '0;
               last_d  = (eff_len == LEN_W'(1)) && (repeat_n == '0);
`else
               last_d  = (eff_len == LEN_W'(1));
`endif
            end
         end
         STREAM: begin
            if (valid_q && dout_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  dout_d = rd_data;
                  last_d = ptr_wrap && final_pass;
                  ptr_d  = ptr_wrap ? '0 : ptr_q + ADDR_W'(1);
`ifdef FILTER_SP_REPEAT_EN
                  pass_d = ptr_wrap ? pass_q + REP_W'(1) : pass_q;
`endif
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         len_q    <= '0;
         ptr_q    <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         wr_err_q <= 1'b0;
`ifdef FILTER_SP_REPEAT_EN
         pass_q   <= '0;
         rep_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         len_q    <= len_d;
         ptr_q    <= ptr_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         wr_err_q <= wen && wr_bad;
`ifdef FILTER_SP_REPEAT_EN
         pass_q   <= pass_d;
         rep_q    <= rep_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign dout_last  = last_q;
   assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_filter_stream_sp.sv
// Directed self-checking bench for filter_stream_sp (default and FILTER_SP_REPEAT_EN builds).
module tb_filter_stream_sp;

   logic        clk = 1'b0;
   logic        rst;
   logic        wen = 1'b0;
   logic [1:0]  wsel = '0;
   logic [3:0]  waddr = '0;
   logic [15:0] din = '0;
   logic        wr_err;
   logic        start = 1'b0;
   logic [1:0]  rsel = '0;
   logic [4:0]  len = '0;
   logic [3:0]  repeat_n = '0;
   logic        flush = 1'b0;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic        dout_last;
   logic        busy;
   logic        done;

   int tests_run = 0;
   int fails     = 0;

   logic [15:0] got_w[$];
   bit          got_l[$];
   bit          done_seen, timed_out, first_valid;
   int          stall_err;

   always #5 clk = ~clk;

   filter_stream_sp dut (
      .clk(clk), .rst(rst), .wen(wen), .wsel(wsel), .waddr(waddr), .din(din),
      .wr_err(wr_err), .start(start), .rsel(rsel), .len(len), .repeat_n(repeat_n),
      .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .busy(busy), .done(done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int f, input int a, input logic [15:0] d);
      wen = 1'b1; wsel = 2'(f); waddr = 4'(a); din = d;
      tick();
      wen = 1'b0;
   endtask

   task automatic start_stream(input int f, input int l, input int r);
      start = 1'b1; rsel = 2'(f); len = 5'(l); repeat_n = 4'(r);
      tick();
      start = 1'b0;
   endtask

   // Collects accepted words until done or budget; mode 0 = always ready, mode 1 = ready 1,0,0,...
   task automatic collect(input int mode, input int budget);
      logic [15:0] pd;
      bit          pl, prev_stall;
      int          cyc;
      got_w.delete(); got_l.delete();
      done_seen = 0; timed_out = 0; stall_err = 0; prev_stall = 0; cyc = 0;
      pd = '0; pl = 0;
      first_valid = dout_valid;
      while (1) begin
         if (done) begin done_seen = 1; break; end
         if (cyc >= budget) begin timed_out = 1; break; end
         dout_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (prev_stall && (dout !== pd || dout_last !== pl)) stall_err++;
         if (dout_valid && dout_ready) begin
            got_w.push_back(dout); got_l.push_back(dout_last); prev_stall = 0;
         end else if (dout_valid) begin
            prev_stall = 1; pd = dout; pl = dout_last;
         end
         tick();
         cyc++;
      end
      dout_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      tests_run++;
      if ({dout, dout_valid, dout_last, busy, done, wr_err} !== 22'h0) begin
         fails++; $display("FAIL reset_outputs: got %h required 0", {dout, dout_valid, dout_last, busy, done, wr_err});
      end
      @(negedge clk); rst = 1'b0;
      tick();
      start_stream(3, 2, 0);
      collect(0, 10);
      tests_run++;
      if (got_w.size() != 2 || got_w[0] !== 16'h0 || got_w[1] !== 16'h0 || timed_out) begin
         fails++; $display("FAIL reset_mem_clear: got %0d words timeout=%0d required 2 zero words", got_w.size(), timed_out);
      end
      tick();
   endtask

   task automatic test_basic();
      for (int f = 0; f < 4; f++)
         for (int a = 0; a < 12; a++)
            wr(f, a, (f == 0) ? 16'(16'h0A0 + a) : (f == 1) ? 16'(16'h200 + a) :
                     (f == 2) ? 16'(16'h100 + a) : 16'(16'h300 + a));
      start_stream(2, 12, 0);
      collect(0, 40);
      tests_run++;
      if (first_valid !== 1'b1) begin fails++; $display("FAIL basic_first_valid: got %0d required 1", first_valid); end
      tests_run++;
      if (got_w.size() != 12 || timed_out) begin
         fails++; $display("FAIL basic_count: got %0d required 12 (timeout=%0d)", got_w.size(), timed_out);
      end else begin
         for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (got_w[i] !== 16'(16'h100 + i) || got_l[i] !== (i == 11)) begin
               fails++; $display("FAIL basic_word%0d: got %h last=%0d required %h last=%0d", i, got_w[i], got_l[i], 16'(16'h100 + i), (i == 11));
            end
         end
      end
      tests_run++;
      if (!done_seen || dout_valid !== 1'b0) begin
         fails++; $display("FAIL basic_done: got done=%0d valid=%0d required done=1 valid=0", done_seen, dout_valid);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL basic_done_pulse: got done=%0d busy=%0d required 0 0", done, busy);
      end
   endtask

   task automatic test_stall();
      start_stream(2, 12, 0);
      collect(1, 80);
      tests_run++;
      if (stall_err != 0) begin fails++; $display("FAIL stall_hold: got %0d changes required 0", stall_err); end
      tests_run++;
      if (got_w.size() != 12 || timed_out) begin
         fails++; $display("FAIL stall_count: got %0d required 12", got_w.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (got_w[i] !== 16'(16'h100 + i) || got_l[i] !== (i == 11)) begin
               fails++; $display("FAIL stall_word%0d: got %h last=%0d required %h", i, got_w[i], got_l[i], 16'(16'h100 + i));
            end
         end
      end
      tick();
   endtask

   task automatic test_write_lock();
      dout_ready = 1'b0;
      start_stream(1, 12, 0);
      wr(1, 3, 16'hDEAD);
      tests_run++;
      if (wr_err !== 1'b1) begin fails++; $display("FAIL lock_wr_err: got %0d required 1", wr_err); end
      wr(0, 3, 16'hBEEF);
      tests_run++;
      if (wr_err !== 1'b0) begin fails++; $display("FAIL other_wr_err: got %0d required 0", wr_err); end
      flush = 1'b1; tick(); flush = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL lock_flush: got busy=%0d done=%0d required 0 0", busy, done); end
      wr(3, 12, 16'h5555);
      tests_run++;
      if (wr_err !== 1'b1) begin fails++; $display("FAIL oob_wr_err: got %0d required 1", wr_err); end
      tick();
      tests_run++;
      if (wr_err !== 1'b0) begin fails++; $display("FAIL wr_err_pulse: got %0d required 0", wr_err); end
      start_stream(1, 4, 0);
      collect(0, 20);
      tests_run++;
      if (got_w.size() != 4 || got_w[3] !== 16'h203) begin
         fails++; $display("FAIL lock_unchanged: got n=%0d w3=%h required 4 203", got_w.size(), (got_w.size() > 3) ? got_w[3] : 16'hxxxx);
      end
      tick();
      start_stream(0, 4, 0);
      collect(0, 20);
      tests_run++;
      if (got_w.size() != 4 || got_w[2] !== 16'h0A2 || got_w[3] !== 16'hBEEF) begin
         fails++; $display("FAIL other_stored: got n=%0d w3=%h required 4 beef", got_w.size(), (got_w.size() > 3) ? got_w[3] : 16'hxxxx);
      end
      tick();
   endtask

   task automatic test_len_clamp();
      int lens[3] = '{0, 15, 1};
      int exp_n[3] = '{12, 12, 1};
      for (int k = 0; k < 3; k++) begin
         start_stream(2, lens[k], 0);
         collect(0, 40);
         tests_run++;
         if (got_w.size() != exp_n[k] || timed_out || !done_seen) begin
            fails++; $display("FAIL len%0d_count: got %0d required %0d", lens[k], got_w.size(), exp_n[k]);
         end else begin
            tests_run++;
            if (got_l[exp_n[k] - 1] !== 1'b1 || got_w[exp_n[k] - 1] !== 16'(16'h100 + exp_n[k] - 1)) begin
               fails++; $display("FAIL len%0d_last: got %h last=%0d required %h last=1", lens[k], got_w[exp_n[k] - 1], got_l[exp_n[k] - 1], 16'(16'h100 + exp_n[k] - 1));
            end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      dout_ready = 1'b1;
      start_stream(2, 12, 0);
      for (int k = 0; k < 5; k++) begin
         tests_run++;
         if (dout !== 16'(16'h100 + k) || dout_valid !== 1'b1) begin
            fails++; $display("FAIL flush_pre_word%0d: got %h valid=%0d required %h", k, dout, dout_valid, 16'(16'h100 + k));
         end
         start = (k == 2); rsel = 2'd0; len = 5'd3;
         tick();
      end
      start = 1'b0;
      tests_run++;
      if (dout !== 16'h105) begin fails++; $display("FAIL flush_word5: got %h required 0105", dout); end
      flush = 1'b1; start = 1'b1;
      tick();
      flush = 1'b0; start = 1'b0;
      tests_run++;
      if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL flush_abort: got valid=%0d busy=%0d done=%0d required 0 0 0", dout_valid, busy, done);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_no_done: got done=%0d busy=%0d required 0 0", done, busy); end
   endtask

   task automatic test_repeat();
      int exp_n;
`ifdef FILTER_SP_REPEAT_EN
      exp_n = 9;
`else
      exp_n = 3;
`endif
      start_stream(2, 3, 2);
      collect(0, 40);
      tests_run++;
      if (got_w.size() != exp_n || timed_out) begin
         fails++; $display("FAIL repeat_count: got %0d required %0d", got_w.size(), exp_n);
      end else begin
         for (int i = 0; i < exp_n; i++) begin
            tests_run++;
            if (got_w[i] !== 16'(16'h100 + (i % 3)) || got_l[i] !== (i == exp_n - 1)) begin
               fails++; $display("FAIL repeat_word%0d: got %h last=%0d required %h last=%0d", i, got_w[i], got_l[i], 16'(16'h100 + (i % 3)), (i == exp_n - 1));
            end
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_write_lock();
      test_len_clamp();
      test_flush();
      test_repeat();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
